fx_meter: RTL and testbench
===========================

Name: fx_meter

Overview:
- Reciprocal frequency counter. It consumes the divided measurement clock that the DSO top drives out on fx_out (the /8 prescaler output).
- It counts synchronised fx rising edges and reference-clock cycles over a gate that opens and closes on fx edges.
- The MCU computes F = F_clk * fx_cnt / ref_cnt, times 8 when the prescaler is on.
- Results are exposed to the SPI register-read decoder as byte slices.

Parameters:
REF_W, 24, width of reference-cycle counter and gate_len
FX_W, 24, width of fx edge counter

Ports:
clk  input  1  system clock; single clock domain
nrst  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  one-cycle pulse from register write; arms a new measurement
gate_len  input  REF_W  minimum gate length in clk cycles; 0 treated as 1
fx_in  input  1  asynchronous measured signal (divided fx)
busy  output  1  measurement in progress (ARM or GATE)
done  output  1  result valid; held until next start or reset
tmo  output  1  last measurement aborted by timeout; valid with done
ref_cnt  output  REF_W  latched reference cycles between opening and closing fx edges
fx_cnt  output  FX_W  latched fx rising edges counted after the opening edge, including the closing edge

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-low.
- Reset values (nrst=0 at a clk edge): state IDLE; busy=0, done=0, tmo=0, ref_cnt=0, fx_cnt=0; synchroniser flops=0; internal counters=0.
- Input synchroniser: fx_in passes through 2 flops plus a delay flop. edge = s1 & ~s2.
  - An edge is seen 2-3 clk after the pin transition.
  - The latency is identical for every edge, so it cancels in the measurement.
  - fx pulses shorter than one clk high or low may be lost (documented limit).
- Internal registers: rc (REF_W), fc (FX_W), gl = max(gate_len,1). gl is captured at start and is stable for the whole measurement.
- IDLE:
  - busy=0.
  - start -> ARM; rc<=0; done<=0; tmo<=0; latch gl.
- ARM (waiting for the opening edge):
  - busy=1.
  - Each cycle rc<=rc+1.
  - On edge: rc<=0, fc<=0 -> GATE.
  - Else if rc+1 == gl (no edge within gl cycles): ref_cnt<=0, fx_cnt<=0, tmo<=1, done<=1 -> IDLE.
- GATE:
  - busy=1.
  - rn = rc+1 (REF_W bits, no wrap), fn = fc+edge.
  - If edge && rn >= gl: ref_cnt<=rn, fx_cnt<=fn, tmo<=0, done<=1 -> IDLE. The gate closes exactly on an fx edge.
  - Else if rn == all-ones(REF_W) (fx stopped mid-gate): ref_cnt<=rn, fx_cnt<=fc, tmo<=1, done<=1 -> IDLE.
  - Else rc<=rn. fc<=fn, saturating at all-ones(FX_W); on saturation the flow is identical and the MCU detects fx_cnt = all-ones.
- done and tmo change only in the same cycle as each other. ref_cnt and fx_cnt are only written in that same done-setting cycle, so readers never see a half-updated result.
- start while busy: abort the current measurement, re-latch gl, go to ARM with rc<=0, and clear done/tmo. Previous result registers remain unchanged until the new result latches.
- start in the same cycle as a closing edge: start wins, the result is discarded, and the block goes to ARM.
- Reset mid-measurement: immediate IDLE with all outputs cleared.
- gate_len change while busy: no effect (gl is latched).
- Latency from the closing edge's sync detect to done=1: 1 clk.

Test Plan:
- Reset with busy forced mid-GATE, nrst=0 one clk -> next cycle busy=0, done=0, tmo=0, ref_cnt=0, fx_cnt=0.
- fx period 10 clk (5 high/5 low), gate_len=100, start -> done=1, tmo=0, ref_cnt=100, fx_cnt=10, busy low the same cycle done rises. Repeat with gate_len=95 -> ref_cnt=100, fx_cnt=10.
- fx period 7 clk, gate_len=50 -> ref_cnt=56, fx_cnt=8. Check fn/rn at the closing edge.
- fx held low, gate_len=20, start -> exactly 20 clk later done=1, tmo=1, ref_cnt=0, fx_cnt=0. Also gate_len=0 -> timeout after 1 clk.
- REF_W=8 build: fx toggles for 3 edges then stops -> done=1, tmo=1, ref_cnt=255, fx_cnt=2.
- start re-pulsed 30 clk into a gate_len=100 measurement -> no done from the first run; second run completes with ref_cnt=100, fx_cnt=10. Old result stays readable until then.

Source files
------------

// File: rtl/fx_meter.sv
// ============================================================================
// fx_meter : reciprocal frequency counter (fx edges vs reference clk cycles)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module fx_meter #(
    parameter int REF_W = 24,
    parameter int FX_W  = 24
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [REF_W-1:0] gate_len,
    input  logic             fx_in,
    output logic             busy,
    output logic             done,
    output logic             tmo,
    output logic [REF_W-1:0] ref_cnt,
    output logic [FX_W-1:0]  fx_cnt
);

    localparam logic [1:0]       ST_IDLE = 2'd0;
    localparam logic [1:0]       ST_ARM  = 2'd1;
    localparam logic [1:0]       ST_GATE = 2'd2;
    localparam logic [REF_W-1:0] REF_MAX = '1;
    localparam logic [FX_W-1:0]  FX_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic             s0_q, s1_q, s2_q;
    logic [REF_W-1:0] rc_q, rc_d;
    logic [FX_W-1:0]  fc_q, fc_d;
    logic [REF_W-1:0] gl_q, gl_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [FX_W-1:0]  fx_cnt_q, fx_cnt_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

    logic             fx_edge;
    logic [REF_W-1:0] rn;
    logic [FX_W-1:0]  fn;

    // s0/s1 resynchronise fx_in, s2 delays s1 so one rising edge is one pulse
    assign fx_edge = s1_q & ~s2_q;
    assign rn      = rc_q + REF_W'(1);
    assign fn      = (fc_q == FX_MAX) ? fc_q : fc_q + FX_W'(fx_edge);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            rc_q      <= '0;
            fc_q      <= '0;
            gl_q      <= '0;
            ref_cnt_q <= '0;
            fx_cnt_q  <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s0_q      <= fx_in;
            s1_q      <= s0_q;
            s2_q      <= s1_q;
            rc_q      <= rc_d;
            fc_q      <= fc_d;
            gl_q      <= gl_d;
            ref_cnt_q <= ref_cnt_d;
            fx_cnt_q  <= fx_cnt_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        fc_d      = fc_q;
        gl_d      = gl_q;
        ref_cnt_d = ref_cnt_q;
        fx_cnt_d  = fx_cnt_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        // start has priority in every state, including over a closing edge
        if (start) begin
            state_d = ST_ARM;
            rc_d    = '0;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
            gl_d    = (gate_len == '0) ? REF_W'(1) : gate_len;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARM: begin
                    if (fx_edge) begin
                        rc_d    = '0;
                        fc_d    = '0;
                        state_d = ST_GATE;
                    end else if (rn == gl_q) begin
                        ref_cnt_d = '0;
                        fx_cnt_d  = '0;
                        tmo_d     = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        rc_d = rn;
                    end
                end
                ST_GATE: begin
                    if (fx_edge && (rn >= gl_q)) begin
                        ref_cnt_d = rn;
                        fx_cnt_d  = fn;
                        tmo_d     = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (rn == REF_MAX) begin
                        ref_cnt_d = rn;
                        fx_cnt_d  = fc_q;
                        tmo_d     = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        rc_d = rn;
                        fc_d = fn;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q == ST_ARM) || (state_q == ST_GATE);
        done    = done_q;
        tmo     = tmo_q;
        ref_cnt = ref_cnt_q;
        fx_cnt  = fx_cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_fx_meter.sv
// ============================================================================
// tb_fx_meter : directed self-checking bench for fx_meter (24-bit and 8-bit)
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_fx_meter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        start8;
    logic [23:0] gate_len;
    logic [7:0]  gate_len8;
    logic        fx_in;
    logic        busy, done, tmo;
    logic [23:0] ref_cnt, fx_cnt;
    logic        busy8, done8, tmo8;
    logic [7:0]  ref_cnt8, fx_cnt8;

    int n_assert = 0;
    int n_fail   = 0;

    bit fx_run = 1'b0;
    int fx_per = 10;
    int fx_hi  = 5;
    int fx_lim = -1;
    int ph     = 0;
    int nedge  = 0;

    int cyc;
    bit ok;

    always #5 clk = ~clk;

    fx_meter #(.REF_W(24), .FX_W(24)) u_dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .gate_len (gate_len),
        .fx_in    (fx_in),
        .busy     (busy),
        .done     (done),
        .tmo      (tmo),
        .ref_cnt  (ref_cnt),
        .fx_cnt   (fx_cnt)
    );

    fx_meter #(.REF_W(8), .FX_W(8)) u_dut8 (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start8),
        .gate_len (gate_len8),
        .fx_in    (fx_in),
        .busy     (busy8),
        .done     (done8),
        .tmo      (tmo8),
        .ref_cnt  (ref_cnt8),
        .fx_cnt   (fx_cnt8)
    );

    // fx waveform generator, stepped once per clk; fx_lim >= 0 caps the rising edges
    initial begin
        bit nxt;
        fx_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!fx_run) begin
                fx_in = 1'b0;
                ph    = 0;
                nedge = 0;
            end else begin
                nxt = (ph < fx_hi);
                if (nxt && !fx_in && fx_lim >= 0 && nedge >= fx_lim) nxt = 1'b0;
                if (nxt && !fx_in) nedge++;
                fx_in = nxt;
                ph    = (ph + 1) % fx_per;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit use8);
        @(negedge clk);
        if (use8) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_done(input bit use8, input int maxc, output int c, output bit got);
        got = 1'b0;
        c   = 0;
        while (c < maxc && !got) begin
            @(negedge clk);
            c++;
            if ((use8 ? done8 : done) === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        nrst      = 1'b0;
        start     = 1'b0;
        start8    = 1'b0;
        gate_len  = 24'd0;
        gate_len8 = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_ref", ref_cnt, 0);
        chk("rst_fx", fx_cnt, 0);
        chk("rst_ref8", ref_cnt8, 0);
        chk("rst_done8", done8, 0);
        nrst = 1'b1;

        // period 10, gate 100: closes on the edge 100 cycles after opening
        fx_per = 10; fx_hi = 5; fx_lim = -1; fx_run = 1'b1;
        repeat (20) @(negedge clk);
        gate_len = 24'd100;
        pulse(1'b0);
        wait_done(1'b0, 400, cyc, ok);
        chk("p10_wait", ok, 1);
        chk("p10_busy_at_done", busy, 0);
        chk("p10_tmo", tmo, 0);
        chk("p10_ref", ref_cnt, 100);
        chk("p10_fx", fx_cnt, 10);

        // gate 95 rounds up to the next fx edge; mid-run gate_len change ignored
        gate_len = 24'd95;
        pulse(1'b0);
        chk("p95_done_clr", done, 0);
        repeat (30) @(negedge clk);
        gate_len = 24'd20;
        wait_done(1'b0, 400, cyc, ok);
        chk("p95_wait", ok, 1);
        chk("p95_ref", ref_cnt, 100);
        chk("p95_fx", fx_cnt, 10);

        // period 7, gate 50: first edge at or after 50 is 56 -> 8 edges
        fx_per = 7; fx_hi = 3;
        repeat (20) @(negedge clk);
        gate_len = 24'd50;
        pulse(1'b0);
        wait_done(1'b0, 400, cyc, ok);
        chk("p7_wait", ok, 1);
        chk("p7_tmo", tmo, 0);
        chk("p7_ref", ref_cnt, 56);
        chk("p7_fx", fx_cnt, 8);

        // restart 30 cycles in: first run discarded, old result held meanwhile
        fx_per = 10; fx_hi = 5;
        repeat (20) @(negedge clk);
        gate_len = 24'd100;
        pulse(1'b0);
        repeat (30) @(negedge clk);
        chk("rs_old_ref", ref_cnt, 56);
        chk("rs_old_fx", fx_cnt, 8);
        chk("rs_busy", busy, 1);
        pulse(1'b0);
        wait_done(1'b0, 400, cyc, ok);
        chk("rs_wait", ok, 1);
        chk("rs_no_early_done", (cyc >= 100) ? 1 : 0, 1);
        chk("rs_ref", ref_cnt, 100);
        chk("rs_fx", fx_cnt, 10);

        // reset in the middle of a gate clears everything
        pulse(1'b0);
        repeat (40) @(negedge clk);
        chk("mr_busy_pre", busy, 1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_tmo", tmo, 0);
        chk("mr_ref", ref_cnt, 0);
        chk("mr_fx", fx_cnt, 0);

        // fx held low, gate 20: timeout exactly 20 clk after the start edge
        fx_run = 1'b0;
        repeat (10) @(negedge clk);
        gate_len = 24'd20;
        pulse(1'b0);
        repeat (19) @(negedge clk);
        chk("to20_early", done, 0);
        @(negedge clk);
        chk("to20_done", done, 1);
        chk("to20_tmo", tmo, 1);
        chk("to20_ref", ref_cnt, 0);
        chk("to20_fx", fx_cnt, 0);

        // gate 0 behaves as 1: timeout one clk after start
        gate_len = 24'd0;
        pulse(1'b0);
        chk("to0_done_clr", done, 0);
        @(negedge clk);
        chk("to0_done", done, 1);
        chk("to0_tmo", tmo, 1);

        // 8-bit build: 3 edges then fx stops -> reference counter runs out
        gate_len8 = 8'd200;
        pulse(1'b1);
        chk("r8_busy", busy8, 1);
        fx_lim = 3; fx_per = 10; fx_hi = 5; fx_run = 1'b1;
        wait_done(1'b1, 600, cyc, ok);
        chk("r8_wait", ok, 1);
        chk("r8_tmo", tmo8, 1);
        chk("r8_ref", ref_cnt8, 255);
        chk("r8_fx", fx_cnt8, 2);
        fx_run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
